// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side bundle for uart_tx_arbiter; requester k owns data lane k.
// master drives the requests and the transmitter busy line; slave is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] i_req_data;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic [NUM_REQ-1:0]           o_grant;
  logic [DATA_BITS-1:0]         o_tx_data;
  logic                         o_tx_write;
  logic                         i_tx_busy;
  logic                         o_active;
  logic                         o_err_timeout;

  modport master (
    output i_req_valid, i_req_data, i_tx_busy,
    input  o_req_ready, o_grant, o_tx_data, o_tx_write, o_active, o_err_timeout
  );

  modport slave (
    input  i_req_valid, i_req_data, i_tx_busy,
    output o_req_ready, o_grant, o_tx_data, o_tx_write, o_active, o_err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ requesters; accept-to-write latency is 1 cycle.
// Requests are held off (ready low) while the transmitter is busy or a frame is owned.
module uart_tx_arbiter #(
  parameter int DATA_BITS     = 8,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 15
) (
  input logic              i_clk,
  input logic              i_rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = ($clog2(START_TIMEOUT + 1) > 4) ? $clog2(START_TIMEOUT + 1) : 4;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ISSUE      = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]           state_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_BITS-1:0] data_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 err_q;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [DATA_BITS-1:0] win_dat;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [NUM_REQ-1:0]   rr_vld;
  int                   rr_k;
  logic                 grant_go;

  // Search starts one past the previous owner and wraps, so each valid requester is served once per round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_k      = 0;
    rr_vld    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_k = int'(last_grant_q) + i;
      if (rr_k >= NUM_REQ) rr_k = rr_k - NUM_REQ;
      rr_vld = bus.i_req_valid >> rr_k;
      if (!win_found && rr_vld[0]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(rr_k);
      end
    end
  end

  always_comb begin
    win_dat = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_idx == IDX_W'(j)) win_dat = bus.i_req_data[j*DATA_BITS +: DATA_BITS];
    end
  end

  assign win_onehot = NUM_REQ'(1) << win_idx;

  // A frame still in flight after reset keeps busy high, which alone blocks the next grant.
  assign grant_go = (state_q == ST_IDLE) && i_rst_n && !bus.i_tx_busy && win_found;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_RST;
      cnt_q        <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_go) begin
            state_q      <= ST_ISSUE;
            grant_q      <= win_onehot;
            data_q       <= win_dat;
            last_grant_q <= win_idx;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_START;
          cnt_q   <= '0;
        end
        ST_WAIT_START: begin
          if (bus.i_tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.i_tx_busy) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready   = grant_go ? win_onehot : '0;
  assign bus.o_grant       = grant_q;
  assign bus.o_tx_data     = data_q;
  assign bus.o_tx_write    = (state_q == ST_ISSUE);
  assign bus.o_active      = (state_q != ST_IDLE);
  assign bus.o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single request, round-robin order, busy hold-off,
// start timeout, mid-frame reset and data hold during a frame.
module tb_uart_tx_arbiter;
  localparam int DB = 8;
  localparam int NR = 4;
  localparam int TO = 15;

  logic i_clk;
  logic i_rst_n;
  int   errors = 0;
  int   checks = 0;
  int   order [5] = '{0, 1, 2, 3, 0};

  uart_tx_arbiter_if #(.DATA_BITS(DB), .NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR), .START_TIMEOUT(TO)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    i_rst_n         = 1'b0;
    bus.i_req_valid = 4'b1111;
    bus.i_req_data  = '0;
    bus.i_tx_busy   = 1'b0;
    tick;
    tick;
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_tx_data", bus.o_tx_data, 0);
    chk("rst_write", bus.o_tx_write, 0);
    chk("rst_active", bus.o_active, 0);
    chk("rst_err", bus.o_err_timeout, 0);

    // single request on lane 2
    i_rst_n         = 1'b1;
    bus.i_req_valid = '0;
    tick;
    bus.i_req_valid = 4'b0100;
    bus.i_req_data  = 32'h00A5_0000;
    #1;
    chk("a_ready", bus.o_req_ready, 32'h4);
    tick;
    bus.i_req_valid = '0;
    #1;
    chk("a_ready_low", bus.o_req_ready, 0);
    chk("a_write", bus.o_tx_write, 1);
    chk("a_tx_data", bus.o_tx_data, 32'hA5);
    chk("a_grant", bus.o_grant, 32'h4);
    chk("a_active", bus.o_active, 1);
    tick;
    chk("a_write_once", bus.o_tx_write, 0);
    bus.i_tx_busy = 1'b1;
    tick;
    bus.i_req_data = 32'hFFFF_FFFF;
    tick;
    chk("a_data_hold", bus.o_tx_data, 32'hA5);
    chk("a_grant_hold", bus.o_grant, 32'h4);
    bus.i_tx_busy = 1'b0;
    tick;
    chk("a_grant_clr", bus.o_grant, 0);
    chk("a_idle", bus.o_active, 0);

    // all four requesting continuously after a reset
    i_rst_n = 1'b0;
    tick;
    i_rst_n = 1'b1;
    chk("b_rst_data", bus.o_tx_data, 0);
    bus.i_req_data  = 32'h1312_1110;
    bus.i_req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("b_ready", bus.o_req_ready, 32'h1 << order[n]);
      tick;
      chk("b_write", bus.o_tx_write, 1);
      chk("b_tx_data", bus.o_tx_data, 32'h10 + order[n]);
      chk("b_grant", bus.o_grant, 32'h1 << order[n]);
      tick;
      bus.i_tx_busy = 1'b1;
      tick;
      tick;
      bus.i_tx_busy = 1'b0;
      tick;
      chk("b_grant_clr", bus.o_grant, 0);
    end

    // request while a previous frame keeps busy high
    bus.i_req_valid = 4'b0010;
    bus.i_tx_busy   = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("c_no_ready", bus.o_req_ready, 0);
      chk("c_no_active", bus.o_active, 0);
      tick;
    end
    bus.i_tx_busy = 1'b0;
    #1;
    chk("c_ready", bus.o_req_ready, 32'h2);
    tick;
    chk("c_grant", bus.o_grant, 32'h2);
    chk("c_tx_data", bus.o_tx_data, 32'h11);
    bus.i_req_valid = '0;
    tick;
    bus.i_tx_busy = 1'b1;
    tick;
    bus.i_tx_busy = 1'b0;
    tick;

    // transmitter never raises busy
    bus.i_req_valid = 4'b1100;
    #1;
    chk("d_ready", bus.o_req_ready, 32'h4);
    tick;
    chk("d_tx_data", bus.o_tx_data, 32'h12);
    tick;
    for (int i = 0; i < TO; i++) begin
      chk("d_wait_ready", bus.o_req_ready, 0);
      chk("d_no_err", bus.o_err_timeout, 0);
      chk("d_wait_active", bus.o_active, 1);
      tick;
    end
    chk("d_err", bus.o_err_timeout, 1);
    chk("d_idle", bus.o_active, 0);
    chk("d_grant_clr", bus.o_grant, 0);
    chk("d_next_ready", bus.o_req_ready, 32'h8);
    tick;
    chk("d_err_pulse", bus.o_err_timeout, 0);
    chk("d_next_grant", bus.o_grant, 32'h8);
    bus.i_req_valid = '0;
    tick;
    bus.i_tx_busy = 1'b1;
    tick;
    chk("e_pre_grant", bus.o_grant, 32'h8);

    // one-cycle reset during WAIT_DONE, frame still on the wire
    i_rst_n         = 1'b0;
    bus.i_req_valid = 4'b0001;
    tick;
    i_rst_n = 1'b1;
    #1;
    chk("e_grant", bus.o_grant, 0);
    chk("e_active", bus.o_active, 0);
    chk("e_tx_data", bus.o_tx_data, 0);
    chk("e_write", bus.o_tx_write, 0);
    chk("e_err", bus.o_err_timeout, 0);
    chk("e_ready", bus.o_req_ready, 0);
    tick;
    chk("e_hold_ready", bus.o_req_ready, 0);
    bus.i_tx_busy = 1'b0;
    #1;
    chk("e_ready_after", bus.o_req_ready, 32'h1);
    tick;
    chk("e_grant0", bus.o_grant, 32'h1);
    chk("e_tx_data0", bus.o_tx_data, 32'h10);
    bus.i_req_valid = '0;
    tick;
    bus.i_tx_busy = 1'b1;
    tick;

    // lane 0 data changes while its frame is in WAIT_DONE
    bus.i_req_data = 32'h1312_115A;
    #1;
    chk("f_data_hold", bus.o_tx_data, 32'h10);
    bus.i_tx_busy = 1'b0;
    tick;
    chk("f_idle", bus.o_active, 0);
    chk("f_grant_clr", bus.o_grant, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8: width of each character handed to the transmitter.
REQ-002 Parameter NUM_REQ, default 4, legal range 2..8: number of requesters sharing one uart_tx.
REQ-003 Parameter START_TIMEOUT, default 15: cycles allowed in WAIT_START for transmitter busy to assert.
REQ-004 Port i_clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 Port i_rst_n  input  1  reset; synchronous and active-low.
REQ-006 Port i_req_valid  input  NUM_REQ  per-requester character-valid.
REQ-007 Port i_req_data  input  NUM_REQ*DATA_BITS  packed characters; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
REQ-008 Port o_req_ready  output  NUM_REQ  per-requester accept strobe; transfer occurs when valid and ready are both high.
REQ-009 Port o_grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when no owner.
REQ-010 Port o_tx_data  output  DATA_BITS  character to uart_tx i_data.
REQ-011 Port o_tx_write  output  1  write strobe to uart_tx i_write.
REQ-012 Port i_tx_busy  input  1  uart_tx o_busy.
REQ-013 Port o_active  output  1  high whenever the state is not IDLE.
REQ-014 Port o_err_timeout  output  1  one-cycle pulse when busy fails to assert after a write.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-016 IDLE: with any i_req_valid high and i_tx_busy low, the block SHALL select a winner, pulse its o_req_ready for that cycle, latch its data, set o_grant, and go to ISSUE.
REQ-017 IDLE with i_tx_busy high SHALL NOT grant, regardless of i_req_valid.
REQ-018 Selection SHALL be round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1 (requester 0 first) and updates at each grant.
REQ-019 At most one o_req_ready bit SHALL be high in any cycle; o_req_ready SHALL be low in every state except IDLE.
REQ-020 ISSUE: o_tx_write high for exactly one cycle with o_tx_data = latched character; next state WAIT_START.
REQ-021 o_tx_data SHALL hold the latched value from ISSUE through WAIT_DONE, independent of i_req_data changes.
REQ-022 WAIT_START: a 4-bit-or-wider counter SHALL count cycles; i_tx_busy high -> WAIT_DONE; START_TIMEOUT cycles elapsed without busy -> pulse o_err_timeout, clear o_grant, go IDLE.
REQ-023 WAIT_DONE: on i_tx_busy low -> clear o_grant, go IDLE; the next grant occurs no earlier than the following cycle.
REQ-024 A requester dropping i_req_valid before being granted SHALL have no effect; it is not remembered.
REQ-025 A granted requester SHALL NOT be re-granted until every other requester with valid high has been served once.
REQ-026 o_active SHALL equal (state != IDLE); o_tx_write SHALL never be high outside ISSUE.

Reset
REQ-027 While i_rst_n is low at a clock edge: state=IDLE, last_grant=NUM_REQ-1, counter=0, latched data=0.
REQ-028 Reset values: o_req_ready=0, o_grant=0, o_tx_data=0, o_tx_write=0, o_active=0, o_err_timeout=0.
REQ-029 Reset mid-frame SHALL abandon the current grant; the in-flight uart frame is not aborted, and REQ-017 holds off the next grant until i_tx_busy falls.

Verification
REQ-030 Single request: valid[2]=1, data 0xA5, idle tx -> ready[2] one cycle, o_tx_write one cycle later with o_tx_data=0xA5, grant=0b0100 until busy falls.
REQ-031 All four valid continuously after reset -> service order 0,1,2,3,0 with one uart frame each.
REQ-032 valid[1]=1 while i_tx_busy=1 from a prior frame -> no ready until busy low, then grant 1.
REQ-033 Transmitter model never asserts busy -> o_err_timeout pulses exactly START_TIMEOUT cycles after WAIT_START entry, FSM back in IDLE, next requester granted.
REQ-034 i_rst_n low for one cycle during WAIT_DONE -> all outputs reset next cycle, no grant until busy falls.
REQ-035 i_req_data[0] changed during WAIT_DONE -> o_tx_data unchanged.
